dmem_arbiter: RTL and testbench

Single-port data-memory arbiter sharing the 256x16 data memory between the CPU datapath (controller-driven DAddr/DWrite path) and a host loader/debug port. It issues at most one access per cycle, gives the CPU priority with a bounded-wait guarantee for the host, and steers the one-cycle-latency read data back to the requester that issued the read. It sits between the CPU datapath and the data-memory instance.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_starve_cnt.sv | 29 ++
 rtl/dmem_arbiter.sv | 95 +++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: return-stage states,
// owner encodings and the default address/data widths of the CPU data path.
package dmem_arbiter_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } ret_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_CPU  = 2'b01;
    localparam logic [1:0] OWNER_HOST = 2'b10;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive denied host cycles; o_at_limit forces the
// host to win the next arbitration.
module dmem_starve_cnt #(
    parameter int MAX_WAIT = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority with bounded host wait, one
// access per cycle, and read-data valid steered to the issuing requester.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          CpuReq,
    input  logic          CpuWr,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWData,
    output logic          CpuGnt,
    output logic          CpuRValid,
    input  logic          HostReq,
    input  logic          HostWr,
    input  logic [AW-1:0] HostAddr,
    input  logic [DW-1:0] HostWData,
    output logic          HostGnt,
    output logic          HostRValid,
    output logic [DW-1:0] RData,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    output logic          MemWr,
    input  logic [DW-1:0] MemRData,
    output logic [1:0]    Owner
);

    ret_state_e r_state;
    ret_state_e w_state_nxt;
    logic       w_at_limit;
    logic       w_host_win;
    logic       w_cpu_win;

    dmem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .i_clk      (Clk),
        .i_rst_n    (Rst),
        .i_clr      (HostGnt || !HostReq),
        .i_inc      (HostReq && !HostGnt),
        .o_at_limit (w_at_limit)
    );

    // A starved host overrides the CPU; otherwise the host only gets idle slots.
    assign w_host_win = HostReq && (w_at_limit || !CpuReq);
    assign w_cpu_win  = CpuReq && !w_host_win;

    assign CpuGnt   = w_cpu_win;
    assign HostGnt  = w_host_win;
    assign MemAddr  = w_cpu_win ? CpuAddr  : (w_host_win ? HostAddr  : '0);
    assign MemWData = w_cpu_win ? CpuWData : (w_host_win ? HostWData : '0);
    assign MemWr    = w_cpu_win ? CpuWr    : (w_host_win ? HostWr    : 1'b0);
    assign RData    = MemRData;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_cpu_win && !CpuWr) begin
            w_state_nxt = CPU_RD;
        end else if (w_host_win && !HostWr) begin
            w_state_nxt = HOST_RD;
        end
    end

    always_comb begin
        CpuRValid  = 1'b0;
        HostRValid = 1'b0;
        Owner      = OWNER_NONE;
        case (r_state)
            CPU_RD: begin
                CpuRValid = 1'b1;
                Owner     = OWNER_CPU;
            end
            HOST_RD: begin
                HostRValid = 1'b1;
                Owner      = OWNER_HOST;
            end
            default: begin
                Owner = OWNER_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x16 one-cycle-latency memory.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        CpuReq = 1'b0, CpuWr = 1'b0;
    logic [7:0]  CpuAddr = '0;
    logic [15:0] CpuWData = '0;
    logic        HostReq = 1'b0, HostWr = 1'b0;
    logic [7:0]  HostAddr = '0;
    logic [15:0] HostWData = '0;
    logic        CpuGnt, CpuRValid, HostGnt, HostRValid, MemWr;
    logic [15:0] RData, MemWData;
    logic [7:0]  MemAddr;
    logic [15:0] r_mem_rdata = '0;
    logic [1:0]  Owner;
    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.AW(8), .DW(16), .MAX_WAIT(3)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .CpuReq(CpuReq), .CpuWr(CpuWr), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGnt(CpuGnt), .CpuRValid(CpuRValid),
        .HostReq(HostReq), .HostWr(HostWr), .HostAddr(HostAddr), .HostWData(HostWData),
        .HostGnt(HostGnt), .HostRValid(HostRValid),
        .RData(RData), .MemAddr(MemAddr), .MemWData(MemWData), .MemWr(MemWr),
        .MemRData(r_mem_rdata), .Owner(Owner)
    );

    always @(posedge Clk) begin
        if (MemWr) mem[MemAddr] <= MemWData;
        r_mem_rdata <= mem[MemAddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic wr, input logic [7:0] addr, input logic [15:0] wd);
        CpuReq = req; CpuWr = wr; CpuAddr = addr; CpuWData = wd;
    endtask

    task automatic set_host(input logic req, input logic wr, input logic [7:0] addr, input logic [15:0] wd);
        HostReq = req; HostWr = wr; HostAddr = addr; HostWData = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h01] = 16'hAAAA;
        mem[8'h02] = 16'h5555;

        // reset state
        next_cycle();
        next_cycle();
        check("rst_cpu_rvalid", 32'(CpuRValid), 32'd0);
        check("rst_host_rvalid", 32'(HostRValid), 32'd0);
        check("rst_owner", 32'(Owner), 32'd0);
        check("rst_gnt_mem", {CpuGnt, HostGnt, MemWr, MemAddr, MemWData}, 32'd0);
        Rst = 1'b1;
        next_cycle();

        // CPU read of 0x10
        set_cpu(1'b1, 1'b0, 8'h10, 16'h0);
        #1;
        check("cpu_rd_gnt", {CpuGnt, HostGnt, MemWr}, 32'b100);
        check("cpu_rd_addr", 32'(MemAddr), 32'h10);
        next_cycle();
        set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        check("cpu_rd_rvalid", {CpuRValid, HostRValid}, 32'b10);
        check("cpu_rd_data", 32'(RData), 32'hBEEF);
        check("cpu_rd_owner", 32'(Owner), 32'd1);

        // host write 0x1234 to 0x20, then host read of 0x20
        next_cycle();
        set_host(1'b1, 1'b1, 8'h20, 16'h1234);
        #1;
        check("host_wr_gnt", {CpuGnt, HostGnt, MemWr}, 32'b011);
        check("host_wr_bus", {MemAddr, MemWData}, {8'h20, 16'h1234});
        next_cycle();
        set_host(1'b1, 1'b0, 8'h20, 16'h0);
        #1;
        check("host_rd_gnt", {CpuGnt, HostGnt, MemWr}, 32'b010);
        check("after_wr_rvalid", {CpuRValid, HostRValid, Owner}, 32'b0000);
        next_cycle();
        set_host(1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        check("host_rd_rvalid", {CpuRValid, HostRValid}, 32'b01);
        check("host_rd_data", 32'(RData), 32'h1234);
        check("host_rd_owner", 32'(Owner), 32'd2);

        // CPU continuous with host held: host wins on the 4th cycle
        next_cycle();
        set_cpu(1'b1, 1'b0, 8'h10, 16'h0);
        set_host(1'b1, 1'b0, 8'h02, 16'h0);
        for (int k = 1; k <= 5; k++) begin
            #1;
            if (k == 4) begin
                check($sformatf("starve_c%0d_gnt", k), {CpuGnt, HostGnt}, 32'b01);
                check("starve_host_addr", 32'(MemAddr), 32'h02);
            end else begin
                check($sformatf("starve_c%0d_gnt", k), {CpuGnt, HostGnt}, 32'b10);
            end
            next_cycle();
        end
        set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
        set_host(1'b0, 1'b0, 8'h00, 16'h0);
        next_cycle();

        // alternating CPU read 0x01 / host read 0x02
        set_cpu(1'b1, 1'b0, 8'h01, 16'h0);
        next_cycle();
        set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
        set_host(1'b1, 1'b0, 8'h02, 16'h0);
        #1;
        check("alt1_cpu", {CpuRValid, HostRValid, Owner, RData}, {1'b1, 1'b0, 2'd1, 16'hAAAA});
        check("alt1_host_gnt", 32'(HostGnt), 32'd1);
        next_cycle();
        set_host(1'b0, 1'b0, 8'h00, 16'h0);
        set_cpu(1'b1, 1'b0, 8'h01, 16'h0);
        #1;
        check("alt2_host", {CpuRValid, HostRValid, Owner, RData}, {1'b0, 1'b1, 2'd2, 16'h5555});
        next_cycle();
        set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        check("alt3_cpu", {CpuRValid, HostRValid, Owner, RData}, {1'b1, 1'b0, 2'd1, 16'hAAAA});
        next_cycle();

        // reset pulsed after a CPU read grant, with the host already denied once
        set_cpu(1'b1, 1'b0, 8'h10, 16'h0);
        set_host(1'b1, 1'b0, 8'h02, 16'h0);
        #1;
        check("pre_rst_gnt", {CpuGnt, HostGnt}, 32'b10);
        next_cycle();
        set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
        set_host(1'b0, 1'b0, 8'h00, 16'h0);
        Rst = 1'b0;
        #1;
        check("midrst_rvalid", {CpuRValid, HostRValid, Owner}, 32'b0000);
        next_cycle();
        Rst = 1'b1;
        next_cycle();
        check("post_rst_rvalid", {CpuRValid, HostRValid, Owner}, 32'b0000);
        // a cleared counter means three more CPU wins before the host
        set_cpu(1'b1, 1'b0, 8'h10, 16'h0);
        set_host(1'b1, 1'b0, 8'h02, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            check($sformatf("post_rst_c%0d_gnt", k), {CpuGnt, HostGnt}, (k == 4) ? 32'b01 : 32'b10);
            next_cycle();
        end
        set_cpu(1'b0, 1'b0, 8'h00, 16'h0);
        set_host(1'b0, 1'b0, 8'h00, 16'h0);
        next_cycle();
        next_cycle();

        // idle for 10 cycles
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("idle_%0d", k),
                  {CpuGnt, HostGnt, MemWr, CpuRValid, HostRValid, MemAddr}, 32'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
